// File: rtl/ldpc_pkg.sv
// Shared LDPC decoder types: LLR width, accumulator width, and the
// saturating narrow from accumulator width back to LLR width.
package ldpc_pkg;

  localparam int LLR_W = 32;
  localparam int ACC_W = LLR_W + 3;

  typedef logic signed [LLR_W-1:0] llr_t;
  typedef logic signed [ACC_W-1:0] acc_t;

  // In range exactly when every bit above the LLR sign bit matches it.
  function automatic llr_t sat_narrow(input acc_t x);
    llr_t y;
    if (x[ACC_W-1:LLR_W-1] == {(ACC_W-LLR_W+1){x[ACC_W-1]}}) begin
      y = x[LLR_W-1:0];
    end else if (x[ACC_W-1]) begin
      y = {1'b1, {(LLR_W-1){1'b0}}};
    end else begin
      y = {1'b0, {(LLR_W-1){1'b1}}};
    end
    return y;
  endfunction

endpackage

// File: rtl/vnu_sat_narrow.sv
// Combinational signed saturator from SUM_W bits down to W bits.
module vnu_sat_narrow
  import ldpc_pkg::*;
#(
  parameter int W     = LLR_W,
  parameter int SUM_W = W + 3
) (
  input  logic signed [SUM_W-1:0] x_i,
  output logic signed [W-1:0]     y_o
);

  generate
    if (W == LLR_W && SUM_W == ACC_W) begin : g_pkg
      assign y_o = sat_narrow(x_i);
    end else begin : g_generic
      logic fits;
      assign fits = (x_i[SUM_W-1:W-1] == {(SUM_W-W+1){x_i[SUM_W-1]}});
      always_comb begin
        if (fits) begin
          y_o = x_i[W-1:0];
        end else if (x_i[SUM_W-1]) begin
          y_o = {1'b1, {(W-1){1'b0}}};
        end else begin
          y_o = {1'b0, {(W-1){1'b1}}};
        end
      end
    end
  endgenerate

endmodule

// File: rtl/vnu_6.sv
// Degree-6 LDPC variable node: extrinsic messages Qi = sat(T - Ri) and
// hard decision P = (T < 0), with T = L + sum(Ri); one registered stage.
module vnu_6
  import ldpc_pkg::*;
#(
  parameter int W     = LLR_W,
  parameter int SUM_W = W + 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic signed [W-1:0] L,
  input  logic signed [W-1:0] R1,
  input  logic signed [W-1:0] R2,
  input  logic signed [W-1:0] R3,
  input  logic signed [W-1:0] R4,
  input  logic signed [W-1:0] R5,
  input  logic signed [W-1:0] R6,
  output logic signed [W-1:0] Q1,
  output logic signed [W-1:0] Q2,
  output logic signed [W-1:0] Q3,
  output logic signed [W-1:0] Q4,
  output logic signed [W-1:0] Q5,
  output logic signed [W-1:0] Q6,
  output logic                P
);

  localparam int N = 6;

  logic signed [W-1:0]     r_in  [N];
  logic signed [SUM_W-1:0] r_ext [N];
  logic signed [SUM_W-1:0] e_sum [N];
  logic signed [W-1:0]     q_d   [N];
  logic signed [W-1:0]     q_q   [N];
  logic signed [SUM_W-1:0] t_sum;
  logic                    p_d;
  logic                    p_q;

  assign r_in[0] = R1;
  assign r_in[1] = R2;
  assign r_in[2] = R3;
  assign r_in[3] = R4;
  assign r_in[4] = R5;
  assign r_in[5] = R6;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_ext
      assign r_ext[gi] = {{(SUM_W-W){r_in[gi][W-1]}}, r_in[gi]};
    end
  endgenerate

  // Three guard bits cover the seven-term sum, so T never wraps.
  always_comb begin
    t_sum = {{(SUM_W-W){L[W-1]}}, L};
    for (int i = 0; i < N; i++) begin
      t_sum = t_sum + r_ext[i];
    end
    p_d = t_sum[SUM_W-1];
  end

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_msg
      assign e_sum[gi] = t_sum - r_ext[gi];
      vnu_sat_narrow #(
        .W     (W),
        .SUM_W (SUM_W)
      ) u_sat (
        .x_i (e_sum[gi]),
        .y_o (q_d[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        q_q[i] <= '0;
      end
      p_q <= 1'b0;
    end else begin
      for (int i = 0; i < N; i++) begin
        q_q[i] <= q_d[i];
      end
      p_q <= p_d;
    end
  end

  assign Q1 = q_q[0];
  assign Q2 = q_q[1];
  assign Q3 = q_q[2];
  assign Q4 = q_q[3];
  assign Q5 = q_q[4];
  assign Q6 = q_q[5];
  assign P  = p_q;

endmodule

// File: tb/tb_vnu_6.sv
// Self-checking bench for vnu_6: directed vectors, reset behaviour and
// randomized vectors against an integer-arithmetic reference model.
module tb_vnu_6;

  logic        clk;
  logic        reset;
  logic signed [31:0] L, R1, R2, R3, R4, R5, R6;
  logic signed [31:0] Q1, Q2, Q3, Q4, Q5, Q6;
  logic        P;

  int n_cmp;
  int n_bad;

  int lv;
  int rv [6];
  int exp_q [6];
  logic exp_p;

  vnu_6 dut (
    .clk   (clk),
    .reset (reset),
    .L     (L),
    .R1    (R1),
    .R2    (R2),
    .R3    (R3),
    .R4    (R4),
    .R5    (R5),
    .R6    (R6),
    .Q1    (Q1),
    .Q2    (Q2),
    .Q3    (Q3),
    .Q4    (Q4),
    .Q5    (Q5),
    .Q6    (Q6),
    .P     (P)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference: exact sum in 64-bit integers, then clamp to the 32-bit range.
  task automatic model();
    longint t, e;
    t = longint'(lv);
    for (int i = 0; i < 6; i++) t += longint'(rv[i]);
    for (int i = 0; i < 6; i++) begin
      e = t - longint'(rv[i]);
      if (e > 64'sd2147483647)        exp_q[i] = 32'h7FFFFFFF;
      else if (e < -64'sd2147483648)  exp_q[i] = 32'h80000000;
      else                            exp_q[i] = int'(e);
    end
    exp_p = (t < 0);
  endtask

  task automatic drive();
    L  = lv;
    R1 = rv[0]; R2 = rv[1]; R3 = rv[2];
    R4 = rv[3]; R5 = rv[4]; R6 = rv[5];
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, ".Q1"}, Q1, exp_q[0]);
    chk({tag, ".Q2"}, Q2, exp_q[1]);
    chk({tag, ".Q3"}, Q3, exp_q[2]);
    chk({tag, ".Q4"}, Q4, exp_q[3]);
    chk({tag, ".Q5"}, Q5, exp_q[4]);
    chk({tag, ".Q6"}, Q6, exp_q[5]);
    chk({tag, ".P"}, {31'd0, P}, {31'd0, exp_p});
  endtask

  task automatic chk_zero(input string tag);
    for (int i = 0; i < 6; i++) exp_q[i] = 0;
    exp_p = 1'b0;
    chk_outputs(tag);
    $display("[%0t] %s: Q=(%0d,%0d,%0d,%0d,%0d,%0d) P=%0b", $time, tag, Q1, Q2, Q3, Q4, Q5, Q6, P);
  endtask

  // Drive current vector, advance one edge, check registered result.
  task automatic step(input string tag);
    drive();
    model();
    @(posedge clk);
    #1;
    chk_outputs(tag);
    $display("[%0t] %s: L=%0d R=(%0d,%0d,%0d,%0d,%0d,%0d) -> Q=(%0d,%0d,%0d,%0d,%0d,%0d) P=%0b",
             $time, tag, lv, rv[0], rv[1], rv[2], rv[3], rv[4], rv[5],
             Q1, Q2, Q3, Q4, Q5, Q6, P);
  endtask

  task automatic set_vec(input int l, input int a, input int b, input int c,
                         input int d, input int e, input int f);
    lv = l;
    rv[0] = a; rv[1] = b; rv[2] = c; rv[3] = d; rv[4] = e; rv[5] = f;
  endtask

  function automatic int pick(input int mode);
    int v;
    case (mode)
      0: v = int'($urandom);
      1: v = int'($urandom_range(0, 200)) - 100;
      default: begin
        case ($urandom_range(0, 3))
          0: v = 32'h7FFFFFFF;
          1: v = 32'h80000000;
          2: v = 0;
          default: v = -1;
        endcase
      end
    endcase
    return v;
  endfunction

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    set_vec(int'($urandom), int'($urandom), int'($urandom), int'($urandom),
            int'($urandom), int'($urandom), int'($urandom));
    drive();
    #1;
    chk_zero("reset_t0");
    @(posedge clk); #1;
    chk_zero("reset_edge1");
    @(posedge clk); #1;
    chk_zero("reset_edge2");
    @(negedge clk);
    reset = 1'b0;

    set_vec(4, -4, 10, 5, -6, 7, 8);
    step("pos_total");
    set_vec(4, -4, 1, -11, -6, 7, 6);
    step("neg_total_b2b");

    // Asynchronous reset in the middle of a cycle, no clock edge involved.
    #2;
    reset = 1'b1;
    #1;
    chk_zero("async_reset_mid");
    @(posedge clk); #1;
    chk_zero("async_reset_hold");
    @(negedge clk);
    reset = 1'b0;

    set_vec(4, -4, 10, 5, -6, 7, 8);
    step("pos_after_reset");
    set_vec(0, 0, 0, 0, 0, 0, 0);
    step("zero_all");
    set_vec(-1, 1, 0, 0, 0, 0, 0);
    step("zero_total");
    set_vec(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF,
            32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF);
    step("sat_pos");
    set_vec(32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000,
            32'h80000000, 32'h80000000, 32'h80000000);
    step("sat_neg");
    set_vec(32'h7FFFFFFF, 32'h80000000, 0, 0, 0, 0, 0);
    step("mixed_ext");

    for (int k = 0; k < 200; k++) begin
      int mode;
      mode = int'($urandom_range(0, 2));
      lv = pick(mode);
      for (int i = 0; i < 6; i++) rv[i] = pick(mode);
      step($sformatf("rand%0d", k));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
